// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH-bit operands,
// with start/busy/done handshake, carry/borrow-in and signed overflow.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] dsum;
    logic             c_msb;
    logic             c_out;
    logic [WIDTH-1:0] acc_nx;

    // Ripple one digit; keep the carry entering its top bit for overflow.
    always_comb begin
        dsum  = '0;
        c_out = carry_q;
        c_msb = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i] = a_q[i] ^ b_q[i] ^ c_out;
            if (i == DIGIT - 1) c_msb = c_out;
            c_out = (a_q[i] & b_q[i]) | (c_out & (a_q[i] ^ b_q[i]));
        end
        acc_nx = WIDTH'({dsum, acc_q} >> DIGIT);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = c_out;
                acc_d   = acc_nx;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    sum_d   = acc_nx;
                    cout_d  = c_out;
                    ovf_d   = c_msb ^ c_out;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three configurations
// (8/1, 8/4, 3/1) sharing one clock and reset.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sub = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] st = '0;

    logic       busy0, done0, cout0, ovf0;
    logic [7:0] sum0;
    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic       busy2, done2, cout2, ovf2;
    logic [2:0] sum2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d81 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub),
        .a(a), .b(b), .cin(cin), .busy(busy0), .done(done0),
        .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d84 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub),
        .a(a), .b(b), .cin(cin), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(3), .DIGIT(1)) u_d31 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub),
        .a(a[2:0]), .b(b[2:0]), .cin(cin), .busy(busy2), .done(done2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0: done_of = done0;
            1: done_of = done1;
            default: done_of = done2;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: busy_of = busy0;
            1: busy_of = busy1;
            default: busy_of = busy2;
        endcase
    endfunction

    // lat: edges from the accepting edge until done is seen
    task automatic run_op(input int sel, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci,
                          input logic sb, output int lat, output int bcnt);
        a = av;
        b = bv;
        cin = ci;
        sub = sb;
        st[sel] = 1'b1;
        tick();
        st[sel] = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done_of(sel) && lat < 40) begin
            if (busy_of(sel)) bcnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, c1, c2, ndone;
        logic [2:0] bb, ex_s;
        logic       cc, ex_o;
        logic [3:0] full;

        tick();
        tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_cout", cout0, 0);
        chk("rst_ovf", ovf0, 0);
        rst_n = 1'b1;
        tick();

        run_op(0, 8'h5A, 8'h3C, 0, 0, lat, bcnt);
        chk("add_lat", lat, 8);
        chk("add_busy_cycles", bcnt, 8);
        chk("add_done_busy", busy0, 0);
        chk("add_sum", sum0, 8'h96);
        chk("add_cout", cout0, 0);
        chk("add_ovf", ovf0, 1);
        tick();
        chk("add_done_pulse", done0, 0);

        run_op(0, 8'h10, 8'h20, 1, 1, lat, bcnt);
        chk("sub_lat", lat, 8);
        chk("sub_sum", sum0, 8'hEF);
        chk("sub_cout", cout0, 0);
        chk("sub_ovf", ovf0, 0);

        run_op(1, 8'hFF, 8'h01, 1, 0, lat, bcnt);
        chk("d4_lat", lat, 2);
        chk("d4_sum", sum1, 8'h01);
        chk("d4_cout", cout1, 1);
        chk("d4_ovf", ovf1, 0);

        // start mid-RUN must be ignored; old result stays visible
        a = 8'h01; b = 8'h01; cin = 0; sub = 0;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        tick();
        tick();
        chk("hold_sum", sum0, 8'hEF);
        a = 8'hAA;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        lat = 0;
        while (!done0 && lat < 40) begin tick(); lat++; end
        chk("ign_lat", lat, 5);
        chk("ign_sum", sum0, 8'h02);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0) ndone++;
        end
        chk("ign_no_queue", ndone, 0);

        // start held high: second op accepted in the done cycle
        a = 8'h03; b = 8'h04; cin = 0; sub = 0;
        st[0] = 1'b1;
        tick();
        c1 = 0;
        while (!done0 && c1 < 40) begin tick(); c1++; end
        chk("b2b_first_sum", sum0, 8'h07);
        a = 8'h10;
        c2 = 0;
        tick();
        c2++;
        while (!done0 && c2 < 40) begin tick(); c2++; end
        st[0] = 1'b0;
        chk("b2b_spacing", c2, 9);
        chk("b2b_second_sum", sum0, 8'h14);

        // reset at digit 4 of 8
        a = 8'hFF; b = 8'h01; cin = 1;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", busy0, 0);
        chk("mrst_done", done0, 0);
        chk("mrst_sum", sum0, 0);
        chk("mrst_cout", cout0, 0);
        chk("mrst_ovf", ovf0, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0) ndone++;
        end
        chk("mrst_no_done", ndone, 0);
        run_op(0, 8'h22, 8'h33, 0, 0, lat, bcnt);
        chk("mrst_fresh_lat", lat, 8);
        chk("mrst_fresh_sum", sum0, 8'h55);
        chk("mrst_fresh_cout", cout0, 0);
        chk("mrst_fresh_ovf", ovf0, 0);

        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 8; x++) begin
                    for (int y = 0; y < 8; y++) begin
                        bb = (s != 0) ? ~3'(y) : 3'(y);
                        cc = (s != 0) ? ~1'(c) : 1'(c);
                        full = 4'(x) + 4'(bb) + 4'(cc);
                        ex_s = full[2:0];
                        ex_o = (x[2] == bb[2]) && (ex_s[2] != x[2]);
                        run_op(2, 8'(x), 8'(y), 1'(c), 1'(s), lat, bcnt);
                        chk("w3_lat", lat, 3);
                        chk("w3_sum", sum2, ex_s);
                        chk("w3_cout", cout2, full[3]);
                        chk("w3_ovf", ovf2, ex_o);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
